// File: rtl/mem_write_checker_pkg.sv
// Shared types and constants for the memory write-sequence checker.
package mem_write_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0]  FC_NONE     = 2'd0;
  localparam logic [1:0]  FC_MISMATCH = 2'd1;
  localparam logic [1:0]  FC_TIMEOUT  = 2'd2;
  localparam logic [31:0] CYC_MAX     = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == CYC_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mwc_trace_buf.sv
// Circular log of the most recent stores; index 0 on the read side is the newest entry.
module mwc_trace_buf
  import mem_write_checker_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_adr,
  input  logic [DW-1:0]                wr_data,
  input  logic [$clog2(DEPTH)-1:0]     sel,
  output logic [AW-1:0]                rd_adr,
  output logic [DW-1:0]                rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] adr_mem_r  [DEPTH];
  logic [DW-1:0] data_mem_r [DEPTH];
  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_s;

  // Write pointer, fill count and storage; clear wins over a same-cycle write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_r <= {PW{1'b0}};
      cnt    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        adr_mem_r[i]  <= {AW{1'b0}};
        data_mem_r[i] <= {DW{1'b0}};
      end
    end else if (clr) begin
      wptr_r <= {PW{1'b0}};
      cnt    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        adr_mem_r[i]  <= {AW{1'b0}};
        data_mem_r[i] <= {DW{1'b0}};
      end
    end else if (wr_en) begin
      adr_mem_r[wptr_r]  <= wr_adr;
      data_mem_r[wptr_r] <= wr_data;
      wptr_r             <= wptr_r + PW'(1);
      cnt                <= (cnt == CW'(DEPTH)) ? cnt : cnt + CW'(1);
    end else begin
      wptr_r <= wptr_r;
    end
  end

  // Newest entry sits just behind the write pointer.
  always_comb begin
    rptr_s  = wptr_r - PW'(1) - sel;
    rd_adr  = adr_mem_r[rptr_s];
    rd_data = data_mem_r[rptr_s];
  end

endmodule

// File: rtl/mem_write_checker.sv
// Watches core stores and checks them against an expected in-order write sequence.
// Optional store trace log enabled by defining MWC_TRACE_EN.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int N_EXP   = 4,
  parameter int N_IGN   = 2,
  parameter int TIMEOUT = 1024
`ifdef MWC_TRACE_EN
  ,
  parameter int TRACE_DEPTH = 8
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         mem_write,
  input  logic [AW-1:0]                data_adr,
  input  logic [DW-1:0]                write_data,
  input  logic [N_EXP*AW-1:0]          exp_adr,
  input  logic [N_EXP*DW-1:0]          exp_data,
  input  logic [N_IGN*AW-1:0]          ign_adr,
  output logic                         done,
  output logic                         pass,
  output logic [1:0]                   fail_code,
  output logic [$clog2(N_EXP+1)-1:0]   match_cnt,
  output logic [31:0]                  cycle_cnt,
  output logic [AW-1:0]                err_adr,
  output logic [DW-1:0]                err_data
`ifdef MWC_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_sel,
  output logic [AW-1:0]                    trace_adr,
  output logic [DW-1:0]                    trace_data,
  output logic [$clog2(TRACE_DEPTH+1)-1:0] trace_cnt
`endif
);

  localparam int MW = $clog2(N_EXP+1);

  state_e        state_r, state_s;
  logic [MW-1:0] match_s;
  logic [31:0]   cyc_s;
  logic [1:0]    fc_s;
  logic [AW-1:0] eadr_s;
  logic [DW-1:0] edata_s;
  logic [AW-1:0] cur_adr_s;
  logic [DW-1:0] cur_data_s;
  logic          ign_hit_s;
  logic          match_hit_s;
  logic          last_s;
  logic          timeout_s;

  // Select the currently expected entry and test the store against it and the scratch list.
  always_comb begin
    cur_adr_s  = {AW{1'b0}};
    cur_data_s = {DW{1'b0}};
    ign_hit_s  = 1'b0;
    for (int i = 0; i < N_EXP; i++) begin
      cur_adr_s  = (match_cnt == MW'(i)) ? exp_adr[i*AW +: AW]  : cur_adr_s;
      cur_data_s = (match_cnt == MW'(i)) ? exp_data[i*DW +: DW] : cur_data_s;
    end
    for (int j = 0; j < N_IGN; j++) begin
      ign_hit_s = ign_hit_s | (ign_adr[j*AW +: AW] == data_adr);
    end
    match_hit_s = (data_adr == cur_adr_s) && (write_data == cur_data_s);
    last_s      = (match_cnt == MW'(N_EXP-1));
    timeout_s   = (cycle_cnt == 32'(TIMEOUT-1));
  end

  // Next-state logic: start re-arms from any state; a final match beats timeout, a mismatch reports itself.
  always_comb begin
    state_s = state_r;
    match_s = match_cnt;
    cyc_s   = cycle_cnt;
    fc_s    = fail_code;
    eadr_s  = err_adr;
    edata_s = err_data;
    if (start) begin
      state_s = ST_RUN;
      match_s = {MW{1'b0}};
      cyc_s   = 32'd0;
      fc_s    = FC_NONE;
      eadr_s  = {AW{1'b0}};
      edata_s = {DW{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_write && match_hit_s) begin
            match_s = match_cnt + MW'(1);
            if (last_s) begin
              state_s = ST_PASS;
            end else if (timeout_s) begin
              state_s = ST_FAIL;
              fc_s    = FC_TIMEOUT;
            end else begin
              cyc_s = sat_inc32(cycle_cnt);
            end
          end else if (mem_write && !ign_hit_s) begin
            state_s = ST_FAIL;
            fc_s    = FC_MISMATCH;
            eadr_s  = data_adr;
            edata_s = write_data;
          end else if (timeout_s) begin
            state_s = ST_FAIL;
            fc_s    = FC_TIMEOUT;
          end else begin
            cyc_s = sat_inc32(cycle_cnt);
          end
        end
        ST_IDLE, ST_PASS, ST_FAIL: begin
          state_s = state_r;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and all status outputs are registered together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      match_cnt <= {MW{1'b0}};
      cycle_cnt <= 32'd0;
      err_adr   <= {AW{1'b0}};
      err_data  <= {DW{1'b0}};
    end else begin
      state_r   <= state_s;
      done      <= (state_s == ST_PASS) || (state_s == ST_FAIL);
      pass      <= (state_s == ST_PASS);
      fail_code <= fc_s;
      match_cnt <= match_s;
      cycle_cnt <= cyc_s;
      err_adr   <= eadr_s;
      err_data  <= edata_s;
    end
  end

`ifdef MWC_TRACE_EN
  logic trace_wr_s;
  assign trace_wr_s = (state_r == ST_RUN) && mem_write && !start;

  mwc_trace_buf #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .reset   (reset),
    .clr     (start),
    .wr_en   (trace_wr_s),
    .wr_adr  (data_adr),
    .wr_data (write_data),
    .sel     (trace_sel),
    .rd_adr  (trace_adr),
    .rd_data (trace_data),
    .cnt     (trace_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: directed runs push expected verdicts, a monitor checks each done.
module tb_mem_write_checker;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start = 1'b0;
  logic          mem_write = 1'b0;
  logic [15:0]   data_adr = 16'd0;
  logic [15:0]   write_data = 16'd0;
  logic [47:0]   exp_adr  = {16'd12, 16'd8, 16'd4};
  logic [47:0]   exp_data = {16'd3, 16'd2, 16'd1};
  logic [111:0]  ign_adr  = {16'd105, 16'd104, 16'd103, 16'd102, 16'd101, 16'd100, 16'd20};
  logic          done, pass;
  logic [1:0]    fail_code;
  logic [1:0]    match_cnt;
  logic [31:0]   cycle_cnt;
  logic [15:0]   err_adr, err_data;
`ifdef MWC_TRACE_EN
  logic [1:0]    trace_sel = 2'd0;
  logic [15:0]   trace_adr, trace_data;
  logic [2:0]    trace_cnt;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        pass;
    logic [1:0]  fc;
    logic [1:0]  mc;
    logic [31:0] cyc;
    logic [15:0] eadr;
    logic [15:0] edata;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic done_prev = 1'b0;

  mem_write_checker #(
    .DW (DW), .AW (AW), .N_EXP (3), .N_IGN (7), .TIMEOUT (16)
`ifdef MWC_TRACE_EN
    , .TRACE_DEPTH (4)
`endif
  ) dut (
    .clk (clk), .reset (reset), .start (start), .mem_write (mem_write),
    .data_adr (data_adr), .write_data (write_data),
    .exp_adr (exp_adr), .exp_data (exp_data), .ign_adr (ign_adr),
    .done (done), .pass (pass), .fail_code (fail_code), .match_cnt (match_cnt),
    .cycle_cnt (cycle_cnt), .err_adr (err_adr), .err_data (err_data)
`ifdef MWC_TRACE_EN
    , .trace_sel (trace_sel), .trace_adr (trace_adr), .trace_data (trace_data),
    .trace_cnt (trace_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input logic p, input logic [1:0] fc, input logic [1:0] mc,
                      input logic [31:0] cyc, input logic [15:0] ea, input logic [15:0] ed);
    exp_t e;
    e.pass = p; e.fc = fc; e.mc = mc; e.cyc = cyc; e.eadr = ea; e.edata = ed;
    sb_q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    mem_write = 1'b1; data_adr = a; write_data = d;
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    check({name, "_done"}, done, 1'b0);
    check({name, "_pass"}, pass, 1'b0);
    check({name, "_fc"}, fail_code, 2'd0);
    check({name, "_mc"}, match_cnt, 2'd0);
    check({name, "_cyc"}, cycle_cnt, 32'd0);
    check({name, "_eadr"}, err_adr, 16'd0);
    check({name, "_edata"}, err_data, 16'd0);
  endtask

  // Monitor: every rising done retires one expected verdict.
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", 1'b1, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_pass", pass, mon_e.pass);
        check("sb_fail_code", fail_code, mon_e.fc);
        check("sb_match_cnt", match_cnt, mon_e.mc);
        check("sb_cycle_cnt", cycle_cnt, mon_e.cyc);
        check("sb_err_adr", err_adr, mon_e.eadr);
        check("sb_err_data", err_data, mon_e.edata);
      end
    end
    done_prev = done;
  end

  initial begin
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 check_zero("reset");
    @(negedge clk); reset = 1'b1;

    // Stores before any start are ignored.
    store(16'd4, 16'd1);
    check("prestart_mc", match_cnt, 2'd0);
    check("prestart_done", done, 1'b0);

    // Out-of-order write to a later entry is a mismatch.
    do_start();
    push(1'b0, 2'd1, 2'd0, 32'd0, 16'd8, 16'd2);
    store(16'd8, 16'd2);
    check("ooo_latency", done, 1'b1);
    store(16'd4, 16'd1);
    check("fail_hold_fc", fail_code, 2'd1);
    check("fail_hold_mc", match_cnt, 2'd0);

    // Restart clears the error; right address with wrong data fails.
    do_start();
    check("restart_fc", fail_code, 2'd0);
    check("restart_eadr", err_adr, 16'd0);
    check("restart_done", done, 1'b0);
    push(1'b0, 2'd1, 2'd0, 32'd0, 16'd4, 16'd9);
    store(16'd4, 16'd9);

    // In-order sequence with a scratch store mixed in passes.
    do_start();
    store(16'd20, 16'd7);
    check("ign_no_change", match_cnt, 2'd0);
    store(16'd4, 16'd1);
    store(16'd8, 16'd2);
    check("mid_mc", match_cnt, 2'd2);
    push(1'b1, 2'd0, 2'd3, 32'd3, 16'd0, 16'd0);
    store(16'd12, 16'd3);
    check("pass_latency", pass, 1'b1);
    store(16'd40, 16'd36);
    check("pass_hold", pass, 1'b1);
    check("pass_hold_fc", fail_code, 2'd0);

    // Timeout after exactly 16 RUN cycles.
    do_start();
    push(1'b0, 2'd2, 2'd0, 32'd15, 16'd0, 16'd0);
    idle(15);
    check("to_not_yet", done, 1'b0);
    check("to_cyc15", cycle_cnt, 32'd15);
    idle(1);
    check("to_done", done, 1'b1);

    // Final match on the timeout cycle: pass wins.
    do_start();
    store(16'd4, 16'd1);
    store(16'd8, 16'd2);
    idle(13);
    push(1'b1, 2'd0, 2'd3, 32'd15, 16'd0, 16'd0);
    store(16'd12, 16'd3);

    // Mismatch on the timeout cycle reports mismatch.
    do_start();
    idle(15);
    push(1'b0, 2'd1, 2'd0, 32'd15, 16'd40, 16'd36);
    store(16'd40, 16'd36);

    // Start while running re-arms; then reset mid-run clears immediately.
    do_start();
    store(16'd4, 16'd1);
    do_start();
    check("rearm_mc", match_cnt, 2'd0);
    check("rearm_cyc", cycle_cnt, 32'd0);
    store(16'd4, 16'd1);
    store(16'd8, 16'd2);
    check("prereset_mc", match_cnt, 2'd2);
    #2 reset = 1'b0;
    #1 check_zero("midrun_reset");
    @(negedge clk); reset = 1'b1;
    store(16'd4, 16'd1);
    check("postreset_mc", match_cnt, 2'd0);
    check("postreset_cyc", cycle_cnt, 32'd0);
    idle(2);
    check("postreset_done", done, 1'b0);

`ifdef MWC_TRACE_EN
    do_start();
    for (int i = 0; i < 6; i++) store(16'(100 + i), 16'(1000 + i));
    check("trace_cnt", trace_cnt, 3'd4);
    trace_sel = 2'd0; #1;
    check("trace_sel0_adr", trace_adr, 16'd105);
    check("trace_sel0_data", trace_data, 16'd1005);
    trace_sel = 2'd3; #1;
    check("trace_sel3_adr", trace_adr, 16'd102);
    check("trace_sel3_data", trace_data, 16'd1002);
    do_start();
    check("trace_clr", trace_cnt, 3'd0);
    #2 reset = 1'b0;
    @(negedge clk); reset = 1'b1;
`endif

    idle(3);
    check("sb_drained", sb_q.size(), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
